// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM encoding and default width.
package alu_seq_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_ADDS = 4'd12;
  localparam logic [3:0] OP_SUBS = 4'd13;
  localparam logic [3:0] OP_MULU = 4'd14;
  localparam logic [3:0] OP_DIVU = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  function automatic logic is_muldiv(input logic [3:0] opcode);
    return (opcode == OP_MULU) || (opcode == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine, one bit per cycle.
module alu_seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             active_reg;
  logic             div_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] lo_reg, hi_reg, b_reg;
  logic [WIDTH-1:0] lo_next, hi_next;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_trial;
  logic             div_ge;

  // lo/hi expose the result of the step in flight so the top can latch the final step directly.
  always_comb begin
    mul_sum   = {1'b0, hi_reg} + {1'b0, (lo_reg[0] ? b_reg : {WIDTH{1'b0}})};
    div_shift = {hi_reg, lo_reg[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_reg};
    div_trial = div_shift[WIDTH-1:0] - b_reg;
    if (div_reg) begin
      hi_next = div_ge ? div_trial : div_shift[WIDTH-1:0];
      lo_next = {lo_reg[WIDTH-2:0], div_ge};
    end else begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end
  end

  assign done = active_reg && (cnt_reg == CNT_W'(WIDTH - 1));
  assign lo   = lo_next;
  assign hi   = hi_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_reg <= 1'b0;
      div_reg    <= 1'b0;
      cnt_reg    <= '0;
      lo_reg     <= '0;
      hi_reg     <= '0;
      b_reg      <= '0;
    end else if (start) begin
      active_reg <= 1'b1;
      div_reg    <= is_div;
      cnt_reg    <= '0;
      lo_reg     <= a;
      hi_reg     <= '0;
      b_reg      <= b;
    end else if (active_reg) begin
      lo_reg  <= lo_next;
      hi_reg  <= hi_next;
      cnt_reg <= cnt_reg + CNT_W'(1);
      if (done) active_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Registered ALU with valid/ready handshake: single-cycle ops finish next edge,
// MULU/DIVU run through the iterative engine for WIDTH cycles.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_hi,
  output logic             overflow,
  output logic             zero
);

  alu_state_t state_reg, state_next;

  logic               accept, md_start, md_done;
  logic [WIDTH-1:0]   md_lo, md_hi;
  logic [WIDTH-1:0]   and_v, or_v, xor_v, nor_v;
  logic [WIDTH-1:0]   sum_v, diff_v, shl_v, shr_v, sra_v;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   out_next;
  logic               ovf_next;
  logic [WIDTH-1:0]   out_reg, hi_reg;
  logic               ovf_reg;

  assign in_ready = (state_reg == ST_IDLE);
  assign accept   = in_valid & in_ready;
  assign md_start = accept & is_muldiv(op);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
      assign and_v[gi] = alu_a[gi] & alu_b[gi];
      assign or_v[gi]  = alu_a[gi] | alu_b[gi];
      assign xor_v[gi] = alu_a[gi] ^ alu_b[gi];
      assign nor_v[gi] = ~(alu_a[gi] | alu_b[gi]);
    end
  endgenerate

  assign shamt  = alu_b[SHAMT_W-1:0];
  assign sum_v  = alu_a + alu_b;
  assign diff_v = alu_a - alu_b;
  assign shl_v  = alu_a << shamt;
  assign shr_v  = alu_a >> shamt;
  assign sra_v  = $signed(alu_a) >>> shamt;

  always_comb begin
    out_next = '0;
    ovf_next = 1'b0;
    case (op)
      OP_ADD:  out_next = sum_v;
      OP_SUB:  out_next = diff_v;
      OP_AND:  out_next = and_v;
      OP_OR:   out_next = or_v;
      OP_XOR:  out_next = xor_v;
      OP_NOR:  out_next = nor_v;
      OP_SLTU: out_next = {{(WIDTH-1){1'b0}}, (alu_a < alu_b)};
      OP_SLT:  out_next = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      OP_SLL:  out_next = shl_v;
      OP_SRL:  out_next = shr_v;
      OP_SRA:  out_next = sra_v;
      OP_ADDS: begin
        out_next = sum_v;
        ovf_next = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum_v[WIDTH-1] != alu_a[WIDTH-1]);
      end
      OP_SUBS: begin
        out_next = diff_v;
        ovf_next = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff_v[WIDTH-1] != alu_a[WIDTH-1]);
      end
      default: out_next = '0;
    endcase
  end

  // DONE always returns to IDLE, so a new op can never be taken in the same cycle a result leaves.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = is_muldiv(op) ? ST_BUSY : ST_DONE;
      ST_BUSY: if (md_done) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      out_reg   <= '0;
      hi_reg    <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept && !is_muldiv(op)) begin
        out_reg <= out_next;
        hi_reg  <= '0;
        ovf_reg <= ovf_next;
      end else if ((state_reg == ST_BUSY) && md_done) begin
        out_reg <= md_lo;
        hi_reg  <= md_hi;
        ovf_reg <= 1'b0;
      end
    end
  end

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .is_div (op == OP_DIVU),
    .a      (alu_a),
    .b      (alu_b),
    .done   (md_done),
    .lo     (md_lo),
    .hi     (md_hi)
  );

  assign out_valid = (state_reg == ST_DONE);
  assign alu_out   = out_reg;
  assign alu_hi    = hi_reg;
  assign overflow  = ovf_reg;
  assign zero      = out_valid && (out_reg == '0);

endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core: expected results are queued at issue and popped on out_valid.
module tb_alu_seq_core;
  import alu_seq_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] alu_a = '0;
  logic [W-1:0] alu_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] alu_out;
  logic [W-1:0] alu_hi;
  logic         overflow;
  logic         zero;

  typedef struct {
    string        tag;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         ovf;
    int           lat;
  } exp_t;

  exp_t         sb_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] last_lo, last_hi;
  logic         last_ovf;

  alu_seq_core #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .alu_hi    (alu_hi),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input string tag, input logic [3:0] o,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] p;
    e.tag = tag;
    e.lo  = '0;
    e.hi  = '0;
    e.ovf = 1'b0;
    e.lat = (o == OP_MULU || o == OP_DIVU) ? W + 1 : 1;
    case (o)
      OP_ADD:  e.lo = a + b;
      OP_SUB:  e.lo = a - b;
      OP_AND:  e.lo = a & b;
      OP_OR:   e.lo = a | b;
      OP_XOR:  e.lo = a ^ b;
      OP_NOR:  e.lo = ~(a | b);
      OP_SLTU: e.lo = (a < b) ? 1 : 0;
      OP_SLT:  e.lo = ($signed(a) < $signed(b)) ? 1 : 0;
      OP_SLL:  e.lo = a << b[4:0];
      OP_SRL:  e.lo = a >> b[4:0];
      OP_SRA:  e.lo = $signed(a) >>> b[4:0];
      OP_ADDS: begin
        e.lo  = a + b;
        e.ovf = (a[W-1] == b[W-1]) && (e.lo[W-1] != a[W-1]);
      end
      OP_SUBS: begin
        e.lo  = a - b;
        e.ovf = (a[W-1] != b[W-1]) && (e.lo[W-1] != a[W-1]);
      end
      OP_MULU: begin
        p    = {32'd0, a} * {32'd0, b};
        e.lo = p[31:0];
        e.hi = p[63:32];
      end
      OP_DIVU: begin
        if (b == 0) begin
          e.lo = '1;
          e.hi = a;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
      default: e.lo = '0;
    endcase
    return e;
  endfunction

  // Called at posedge+1. Issues one op, waits for the result, holds out_ready low
  // for `hold` cycles, then releases it while offering another op that must be refused.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold);
    exp_t         e;
    int           wait_cyc;
    int           lat;
    bit           rdy_leak;
    bit           stable;
    logic [W-1:0] lo0, hi0;
    wait_cyc = 0;
    while (!in_ready && wait_cyc < 100) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    check_val({tag, "_in_ready"}, in_ready, 1);
    op = o; alu_a = a; alu_b = b; in_valid = 1'b1;
    sb_q.push_back(model(tag, o, a, b));
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 4'($urandom_range(0, 15)); alu_a = $urandom; alu_b = $urandom;
    lat = 1;
    rdy_leak = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_leak = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    e = sb_q.pop_front();
    check_val({e.tag, "_latency"}, lat, e.lat);
    if (e.lat > 1) check_val({e.tag, "_busy_ready_low"}, rdy_leak, 0);
    check_val({e.tag, "_lo"}, alu_out, e.lo);
    check_val({e.tag, "_hi"}, alu_hi, e.hi);
    check_val({e.tag, "_ovf"}, overflow, e.ovf);
    check_val({e.tag, "_zero"}, zero, (e.lo == 0));
    last_lo = alu_out; last_hi = alu_hi; last_ovf = overflow;
    lo0 = alu_out; hi0 = alu_hi;
    stable = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (!out_valid || alu_out !== lo0 || alu_hi !== hi0) stable = 1'b0;
    end
    if (hold > 0) check_val({e.tag, "_hold_stable"}, stable, 1);
    out_ready = 1'b1;
    in_valid = 1'b1; op = OP_ADD; alu_a = 1; alu_b = 1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val({e.tag, "_bubble_no_accept"}, out_valid, 0);
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]   ro;
    logic [W-1:0] ra, rb;
    bit           early;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_alu_out", alu_out, 0);
    check_val("rst_alu_hi", alu_hi, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_zero", zero, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("rst_in_ready", in_ready, 1);

    run_op("add_wrap", OP_ADD, 32'h7FFF_FFFF, 32'h1, 0);
    check_val("add_wrap_k", last_lo, 32'h8000_0000);
    run_op("adds_ovf", OP_ADDS, 32'h7FFF_FFFF, 32'h1, 0);
    check_val("adds_ovf_k", last_ovf, 1);
    run_op("subs_ovf", OP_SUBS, 32'h8000_0000, 32'h1, 0);
    check_val("subs_ovf_k", {last_ovf, last_lo}, {1'b1, 32'h7FFF_FFFF});
    run_op("sub_zero", OP_SUB, 32'd5, 32'd5, 0);
    run_op("sra_neg", OP_SRA, 32'h8000_0000, 32'd4, 0);
    check_val("sra_neg_k", last_lo, 32'hF800_0000);
    run_op("slt_neg", OP_SLT, 32'hFFFF_FFFF, 32'd1, 0);
    check_val("slt_neg_k", last_lo, 1);
    run_op("sltu_big", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 0);
    check_val("sltu_big_k", last_lo, 0);
    run_op("sll_hibits", OP_SLL, 32'h0000_00F1, 32'hFFFF_FFE4, 0);
    run_op("srl", OP_SRL, 32'hF000_000F, 32'd31, 0);
    run_op("nor", OP_NOR, 32'h0F0F_0000, 32'h00F0_F0F0, 0);
    run_op("nop", OP_NOP, 32'h1234_5678, 32'h1, 0);
    run_op("mulu", OP_MULU, 32'hFFFF_FFFF, 32'd2, 0);
    check_val("mulu_k", {last_hi, last_lo}, 64'h1_FFFF_FFFE);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, 0);
    check_val("divu_k", {last_hi, last_lo}, {32'd2, 32'd14});
    run_op("divu_zero", OP_DIVU, 32'hCAFE_0123, 32'd0, 5);
    check_val("divu_zero_k", {last_hi, last_lo}, {32'hCAFE_0123, 32'hFFFF_FFFF});

    for (int i = 0; i < 24; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      run_op("rand", ro, ra, rb, $urandom_range(0, 2));
    end

    op = OP_DIVU; alu_a = 32'd1000; alu_b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_val("mid_busy_in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_out_valid", out_valid, 0);
    check_val("mid_rst_alu_out", alu_out, 0);
    check_val("mid_rst_alu_hi", alu_hi, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("mid_rst_in_ready", in_ready, 1);
    early = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) early = 1'b1;
    end
    check_val("mid_rst_no_stale_result", early, 0);
    run_op("add_post_rst", OP_ADD, 32'd2, 32'd3, 0);
    check_val("add_post_rst_k", last_lo, 5);

    check_val("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
